// File: rtl/tcb_peri_uart_rx_fifo_pkg.sv
// Shared helpers for the UART receive FIFO: per-cycle operation bundle
// and the sticky-flag update rule.
package tcb_peri_uart_rx_fifo_pkg;

  // Decoded operation for one clock cycle.
  typedef struct packed {
    logic push;   // byte accepted into storage
    logic pop;    // head entry consumed
    logic drop;   // byte lost because the FIFO was full and nothing left
    logic flush;  // pointers return to zero
  } rxf_op_t;

  // Sticky flag update where a new set event always beats a clear.
  function automatic logic sticky_next(input logic flag_q,
                                       input logic set,
                                       input logic clr);
    return set | (flag_q & ~clr);
  endfunction

endpackage

// File: rtl/tcb_peri_uart_rx_fifo.sv
// UART receive FIFO: first-word fall-through buffer between the
// deserializer byte stream (no backpressure) and a consumer, with a
// sticky overflow flag and a fill-level interrupt.
module tcb_peri_uart_rx_fifo
  import tcb_peri_uart_rx_fifo_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  // deserializer stream
  input  logic              str_vld,
  input  logic [DW-1:0]     str_dat,
  // consumer side
  output logic              out_vld,
  output logic [DW-1:0]     out_dat,
  input  logic              out_rdy,
  // control / status
  input  logic [$clog2(DEPTH):0] cfg_lvl,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic [$clog2(DEPTH):0] cnt,
  output logic              ovf,
  output logic              irq_lvl
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          empty;
  logic          full;
  rxf_op_t       op;

  // Occupancy and status flags come straight from the registered pointers.
  always_comb begin
    cnt   = wr_ptr_q - rd_ptr_q;
    empty = (cnt == '0);
    full  = (cnt == FULL_CNT);
  end

  // Decode this cycle's push / pop / drop; a pop frees a slot so a full
  // FIFO can still accept a byte in the same cycle.
  always_comb begin
    op       = '0;
    op.flush = flush;
    op.pop   = ~empty & out_rdy;
    op.push  = str_vld & (~full | op.pop);
    op.drop  = str_vld & full & ~op.pop;
  end

  // Next-state pointers; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (op.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (op.push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (op.pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Overflow flag: a dropped byte sets it, even against a clear request.
  always_comb begin
    ovf_d = sticky_next(ovf_q, op.drop, ovf_clr);
  end

  // Pointer and flag registers; reset discards all contents at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array, deliberately without reset; stale data is never
  // visible because out_vld is derived from the pointers.
  always_ff @(posedge clk) begin
    if (op.push && !op.flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= str_dat;
    end
  end

  // Output view: head entry falls through, interrupt on fill threshold.
  always_comb begin
    out_vld = ~empty;
    out_dat = mem_q[rd_ptr_q[AW-1:0]];
    ovf     = ovf_q;
    irq_lvl = (cfg_lvl != '0) && (cnt >= cfg_lvl);
  end

endmodule

// File: tb/tb_tcb_peri_uart_rx_fifo.sv
// Testbench for the UART receive FIFO (DW=8, DEPTH=16).
module tb_tcb_peri_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          str_vld;
  logic [DW-1:0] str_dat;
  logic          out_vld;
  logic [DW-1:0] out_dat;
  logic          out_rdy;
  logic [4:0]    cfg_lvl;
  logic          flush;
  logic          ovf_clr;
  logic [4:0]    cnt;
  logic          ovf;
  logic          irq_lvl;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of bytes expected at the output, plus model overflow flag.
  logic [7:0] exp_q[$];
  logic       m_ovf;

  tcb_peri_uart_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .str_vld (str_vld),
    .str_dat (str_dat),
    .out_vld (out_vld),
    .out_dat (out_dat),
    .out_rdy (out_rdy),
    .cfg_lvl (cfg_lvl),
    .flush   (flush),
    .ovf_clr (ovf_clr),
    .cnt     (cnt),
    .ovf     (ovf),
    .irq_lvl (irq_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       fl;
    logic       oc;
    logic [4:0] lvl;
    logic [4:0] e_cnt;
    logic       e_vld;
    logic       e_ovf;
    logic       e_irq;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, scoreboard pop/push, advance, check flags.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r,
                     input logic f, input logic c);
    bit m_pop, m_full, m_push;
    str_vld = v; str_dat = d; out_rdy = r; flush = f; ovf_clr = c;
    #1;
    chk("out_vld", out_vld, exp_q.size() != 0);
    chk("cnt", cnt, exp_q.size());
    m_pop  = (exp_q.size() != 0) && r;
    m_full = (exp_q.size() == DEPTH);
    m_push = v && (!m_full || m_pop);
    if (m_pop) begin
      chk("out_dat", out_dat, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (f) exp_q.delete();
    else if (m_push) exp_q.push_back(d);
    if (v && m_full && !m_pop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(posedge clk); #1;
    chk("ovf", ovf, m_ovf);
    chk("irq_lvl", irq_lvl, (cfg_lvl != 0) && (exp_q.size() >= cfg_lvl));
    $display("cyc t=%0t vld=%0b dat=%02h rdy=%0b fl=%0b oc=%0b -> cnt=%0d ovf=%0b irq=%0b",
             $time, v, d, r, f, c, cnt, ovf, irq_lvl);
    str_vld = 1'b0; out_rdy = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_empty_vld", out_vld, 1'b0);
    chk("drain_empty_cnt", cnt, 0);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_cnt", cnt, 16);
  endtask

  initial begin
    //            vld  dat    rdy  fl   oc   lvl | cnt vld  ovf  irq  dat
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 5'd4, 5'd1, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[6]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b1, 8'h02};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 8'h03};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 8'h03};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 8'h03};
    vecs[10] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};

    rst = 1'b0; str_vld = 1'b0; str_dat = '0; out_rdy = 1'b0;
    cfg_lvl = '0; flush = 1'b0; ovf_clr = 1'b0; m_ovf = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", cnt, 0);
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_irq", irq_lvl, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven: single byte, threshold, push+pop, flush
    for (int i = 0; i < 11; i++) begin
      cfg_lvl = vecs[i].lvl;
      cyc(vecs[i].vld, vecs[i].dat, vecs[i].rdy, vecs[i].fl, vecs[i].oc);
      chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d_vld", i), out_vld, vecs[i].e_vld);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].e_ovf);
      chk($sformatf("vec%0d_irq", i), irq_lvl, vecs[i].e_irq);
      if (vecs[i].e_vld) chk($sformatf("vec%0d_dat", i), out_dat, vecs[i].e_dat);
    end

    // Fill and wrap; cfg_lvl=0 keeps irq low even when full
    cfg_lvl = 5'd0;
    fill(8'h00);
    chk("lvl0_full_irq", irq_lvl, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_cnt8", cnt, 8);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("wrap_cnt16", cnt, 16);
    chk("wrap_head", out_dat, 8'h08);
    drain();

    // Full with concurrent pop: byte accepted, no overflow, read last
    fill(8'h30);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpop_cnt", cnt, 16);
    chk("fullpop_ovf", ovf, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fullpop_last", out_dat, 8'h55);
    drain();

    // Overflow, set-wins-over-clear, then clear
    fill(8'h40);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_cnt", cnt, 16);
    chk("ovf_head", out_dat, 8'h40);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", ovf, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    chk("ovf_setwins", ovf, 1'b1);
    drain();

    // Flush with push at cnt=5: empty next cycle, ovf untouched
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_flush_cnt", cnt, 5);
    cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    chk("flush_cnt", cnt, 0);
    chk("flush_ovf", ovf, 1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    str_vld = 1'b1; str_dat = 8'h99;
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_vld", out_vld, 1'b0);
    @(posedge clk); #1;
    chk("arst_ignore_vld", cnt, 0);
    str_vld = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Resume after reset
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("resume_dat", out_dat, 8'h3C);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tcb_peri_uart_rx_fifo.md
TCB_PERI_UART_RX_FIFO -- requirements
Module: tcb_peri_uart_rx_fifo

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DW SHALL default to 8 and set the data width, matching the deserializer stream width.
REQ-003 Parameter DEPTH SHALL default to 16 and set the entry count; it must be a power of two, at least 2.
REQ-004 Localparam AW SHALL equal $clog2(DEPTH) and set the pointer index width.
REQ-005 Port clk SHALL be an input, 1 bit wide, and serve as the system clock; all state is on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide, and serve as the asynchronous active-low reset.
REQ-007 Port str_vld SHALL be an input, 1 bit wide, carrying the deserializer byte-valid strobe; there is no ready (no backpressure).
REQ-008 Port str_dat SHALL be an input, DW bits wide, carrying the deserializer data, sampled when str_vld=1.
REQ-009 Port out_vld SHALL be an output, 1 bit wide, asserted when the FIFO is not empty.
REQ-010 Port out_dat SHALL be an output, DW bits wide, presenting the head entry (first-word fall-through).
REQ-011 Port out_rdy SHALL be an input, 1 bit wide, from the consumer; a pop occurs on out_vld & out_rdy.
REQ-012 Port cfg_lvl SHALL be an input, AW+1 bits wide, holding the interrupt fill threshold; 0 disables the interrupt.
REQ-013 Port flush SHALL be an input, 1 bit wide; it is a synchronous empty request.
REQ-014 Port ovf_clr SHALL be an input, 1 bit wide, that clears the overflow flag.
REQ-015 Port cnt SHALL be an output, AW+1 bits wide, giving the current occupancy, 0..DEPTH.
REQ-016 Port ovf SHALL be an output, 1 bit wide: a sticky flag that a byte was dropped.
REQ-017 Port irq_lvl SHALL be an output, 1 bit wide, asserted when cfg_lvl != 0 and cnt >= cfg_lvl.

Function
REQ-018 Write and read pointers SHALL be AW+1 bits and wrap modulo 2*DEPTH; cnt = wr_ptr - rd_ptr, truncated to AW+1 bits.
REQ-019 empty = (cnt == 0); full = (cnt == DEPTH).
REQ-020 A push SHALL occur when str_vld=1 and (full=0, or a pop occurs in the same cycle).
REQ-021 When str_vld=1, full=1 and no pop occurs, the byte SHALL be dropped, the pointers unchanged, and ovf set on the next edge.
REQ-022 A pushed byte SHALL appear on out_vld/out_dat on the cycle after str_vld (one-cycle latency) if the FIFO was empty.
REQ-023 A pop SHALL advance rd_ptr; out_dat SHALL show the next entry on the following cycle, or out_vld SHALL drop if it was the last entry.
REQ-024 Simultaneous push and pop SHALL leave cnt unchanged, at any fill level including 1 and DEPTH.
REQ-025 out_dat SHALL be don't-care while out_vld=0; out_rdy while out_vld=0 SHALL have no effect.
REQ-026 flush=1 SHALL set wr_ptr = rd_ptr = 0 on the next edge, overriding any push or pop in that cycle; ovf is not affected.
REQ-027 If ovf_clr=1 and a new overflow occur in the same cycle, ovf SHALL remain 1 (set wins).
REQ-028 irq_lvl and cnt SHALL be derived combinationally from the registered pointers, so they update one cycle after the push or pop.
REQ-029 Storage SHALL be a DW x DEPTH register array with no reset, written at wr_ptr[AW-1:0].

Reset
REQ-030 While rst=0, wr_ptr, rd_ptr and ovf SHALL be 0, giving out_vld=0, cnt=0 and irq_lvl=0.
REQ-031 Reset asserted mid-operation SHALL discard all contents immediately (asynchronously); str_vld during reset SHALL be ignored.
REQ-032 The storage array SHALL NOT be reset.

Structure
REQ-033 No shared package typedefs are required; DW and DEPTH are passed from the UART top alongside the deserializer parameters.
REQ-034 The pointer, flag and storage logic SHALL be self-contained in a single module with no sub-modules.

Verification
REQ-035 Single byte: str_vld with 0xA5 on cycle N -> out_vld=1 and out_dat=0xA5 on N+1, cnt=1; pop -> cnt=0 and out_vld=0.
REQ-036 Fill and wrap: DEPTH=16, push 0x00..0x0F -> cnt=16; pop 8, push 0x10..0x17, pop all -> output order 0x00..0x17, cnt=0.
REQ-037 Overflow: fill 16, push 0xEE with no pop -> ovf=1, 0xEE absent, cnt=16; ovf_clr -> ovf=0.
REQ-038 Full with concurrent pop: at cnt=16, push 0x55 with pop in the same cycle -> cnt=16, ovf=0, 0x55 read last.
REQ-039 Threshold: cfg_lvl=4 -> irq_lvl=0 at cnt=3 and 1 at cnt=4; cfg_lvl=0 -> irq_lvl=0 at cnt=16.
REQ-040 Flush and reset: flush with simultaneous push at cnt=5 -> cnt=0 next cycle, ovf unchanged; rst low mid-stream -> cnt=0 and ovf=0 immediately.
